// File: rtl/tcb_lib_register_response_pipe_pkg.sv
// rtl/tcb_lib_register_response_pipe_pkg.sv - shared tracker types and chunk helper for the TCB response pipe
package tcb_lib_register_response_pipe_pkg;

  // widest byte-enable the tracker can carry; narrower buses leave upper bits zero
  localparam int BEW_MAX = 32;

  typedef struct packed {
    logic               trn;
    logic               ren;
    logic [BEW_MAX-1:0] ben;
  } trk_t;

  // collapse byte enables into one enable per GRN-byte chunk
  function automatic logic [BEW_MAX-1:0] ben_to_chunk(input logic [BEW_MAX-1:0] ben, input int grn);
    logic [BEW_MAX-1:0] chk;
    chk = '0;
    for (int i = 0; i < BEW_MAX; i++) begin
      if (ben[i]) chk[i / grn] = 1'b1;
    end
    return chk;
  endfunction

endpackage

// File: rtl/tcb_lib_register_response_pipe_stage.sv
// rtl/tcb_lib_register_response_pipe_stage.sv - one hold-capable rdt/err register stage with chunk enables
module tcb_lib_register_response_stage #(
  parameter int DBW = 32,
  parameter int NCH = 4,
  parameter int CHW = 8
)(
  input  logic           clk,
  input  logic           rst,
  input  logic [NCH-1:0] ld,
  input  logic [DBW-1:0] din,
  input  logic           vld,
  input  logic           err_in,
  output logic [DBW-1:0] dout,
  output logic           err_out
);

  always_ff @(posedge clk) begin
    if (rst) begin
      dout    <= '0;
      err_out <= 1'b0;
    end else begin
      for (int c = 0; c < NCH; c++) begin
        if (ld[c]) dout[c*CHW +: CHW] <= din[c*CHW +: CHW];
      end
      // error is a pulse: only a tracked transfer may carry it forward
      err_out <= vld & err_in;
    end
  end

endmodule

// File: rtl/tcb_lib_register_response_pipe.sv
// rtl/tcb_lib_register_response_pipe.sv - TCB response-path register pipeline with STG stages and in-flight counter
module tcb_lib_register_response_pipe
  import tcb_lib_register_response_pipe_pkg::*;
#(
  parameter int ABW = 32,
  parameter int DBW = 32,
  parameter int SLW = 8,
  parameter int BEW = DBW/SLW,
  parameter int DLY = 1,
  parameter int STG = 1,
  parameter int GRN = 1,
  parameter int HLD = 1,
  localparam int DEP = DLY + STG,
  localparam int CW  = (DEP == 0) ? 1 : $clog2(DEP + 1)
)(
  input  logic           clk,
  input  logic           rst,
  input  logic           sub_vld,
  input  logic           sub_wen,
  input  logic [ABW-1:0] sub_adr,
  input  logic [BEW-1:0] sub_ben,
  input  logic [DBW-1:0] sub_wdt,
  output logic           sub_rdy,
  output logic [DBW-1:0] sub_rdt,
  output logic           sub_err,
  output logic           man_vld,
  output logic           man_wen,
  output logic [ABW-1:0] man_adr,
  output logic [BEW-1:0] man_ben,
  output logic [DBW-1:0] man_wdt,
  input  logic           man_rdy,
  input  logic [DBW-1:0] man_rdt,
  input  logic           man_err,
  output logic [CW-1:0]  cnt
);

  localparam int NCH = BEW / GRN;
  localparam int CHW = SLW * GRN;
  localparam int TN  = (DEP >= 2) ? DEP - 1 : 0;

  if ((GRN < 1) || ((BEW % GRN) != 0)) begin : g_bad_grn
    $error("GRN must divide BEW");
  end
  if ((STG < 0) || (STG > 4)) begin : g_bad_stg
    $error("STG must be 0..4");
  end
  if ((DLY < 0) || (DLY > 8)) begin : g_bad_dly
    $error("DLY must be 0..8");
  end
  if ((BEW > BEW_MAX) || (DBW != BEW * SLW)) begin : g_bad_bew
    $error("BEW must equal DBW/SLW and fit the tracker");
  end

  assign man_vld = sub_vld;
  assign man_wen = sub_wen;
  assign man_adr = sub_adr;
  assign man_ben = sub_ben;
  assign man_wdt = sub_wdt;
  assign sub_rdy = man_rdy;

  logic trn;
  assign trn = sub_vld & man_rdy;

  trk_t cur;
  trk_t tap [0:TN];

  always_comb begin
    cur              = '0;
    cur.trn          = trn;
    cur.ren          = ~sub_wen;
    cur.ben[BEW-1:0] = sub_ben;
  end

  // tap j describes the transfer made j cycles ago; tap 0 is the live request
  if (DEP >= 2) begin : g_trk
    trk_t trk_q [1:DEP-1];
    always_ff @(posedge clk) begin
      if (rst) begin
        for (int j = 1; j < DEP; j++) trk_q[j] <= '0;
      end else begin
        trk_q[1] <= cur;
        for (int j = 2; j < DEP; j++) trk_q[j] <= trk_q[j-1];
      end
    end
    always_comb begin
      tap[0] = cur;
      for (int j = 1; j < DEP; j++) tap[j] = trk_q[j];
    end
  end else begin : g_trk_none
    always_comb tap[0] = cur;
  end

  // ret_q marks the cycle a response is presented upstream; it retires after that cycle
  if (DEP >= 1) begin : g_cnt
    logic ret_q;
    always_ff @(posedge clk) begin
      if (rst) begin
        ret_q <= 1'b0;
        cnt   <= '0;
      end else begin
        ret_q <= tap[DEP-1].trn;
        if (trn && !ret_q)      cnt <= cnt + 1'b1;
        else if (!trn && ret_q) cnt <= cnt - 1'b1;
      end
    end
  end else begin : g_cnt_none
    assign cnt = '0;
  end

  logic [DBW-1:0] rdt_c [0:STG];
  logic           err_c [0:STG];

  assign rdt_c[0] = man_rdt;
  assign err_c[0] = man_err;

  for (genvar k = 0; k < STG; k++) begin : g_stg
    trk_t           tp;
    logic [NCH-1:0] ld;

    assign tp = tap[k + DLY];

    always_comb begin
      ld = '1;
      if (HLD != 0) ld = (tp.trn && tp.ren) ? NCH'(ben_to_chunk(tp.ben, GRN)) : '0;
    end

    tcb_lib_register_response_stage #(
      .DBW (DBW),
      .NCH (NCH),
      .CHW (CHW)
    ) u_stg (
      .clk     (clk),
      .rst     (rst),
      .ld      (ld),
      .din     (rdt_c[k]),
      .vld     (tp.trn),
      .err_in  (err_c[k]),
      .dout    (rdt_c[k+1]),
      .err_out (err_c[k+1])
    );
  end

  assign sub_rdt = rdt_c[STG];
  assign sub_err = err_c[STG];

endmodule
